// File: rtl/tcp_tx_pkg.sv
// Shared constants for the TCP transmit framer: FSM encoding, byte-index width,
// and the byte-lane selector used for both byte orders.
package tcp_tx_pkg;

    localparam int IDX_W = 2;

    typedef logic [IDX_W-1:0] byte_idx_t;

    localparam byte_idx_t LAST_IDX = 2'd3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SEND  = 2'd1;
    localparam logic [1:0] ST_CLOSE = 2'd2;

    // Byte n of a word in transmit order: MSB-first sends [31:24] first.
    function automatic logic [7:0] select_byte(input logic [31:0] word,
                                               input byte_idx_t   idx,
                                               input bit          msb_first);
        logic [4:0] shift;
        shift = msb_first ? {LAST_IDX - idx, 3'b000} : {idx, 3'b000};
        return 8'(word >> shift);
    endfunction

endpackage

// File: rtl/tcp_tx_framer_if.sv
// Bundle of the upstream FWFT FIFO and downstream TCP user-port signals.
// The framer takes the master side; the FIFO/TCP environment takes the slave side.
interface tcp_tx_framer_if;

    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ;
    logic        USR_ACTIVE;
    logic        USR_CLOSE_REQ;
    logic        USR_CLOSE_ACK;
    logic        USR_TX_AFULL;
    logic        USR_TX_WE;
    logic [7:0]  USR_TX_WD;

    modport master (
        input  FIFO_EMPTY, FIFO_DATA, USR_ACTIVE, USR_CLOSE_REQ, USR_TX_AFULL,
        output FIFO_READ, USR_CLOSE_ACK, USR_TX_WE, USR_TX_WD
    );

    modport slave (
        output FIFO_EMPTY, FIFO_DATA, USR_ACTIVE, USR_CLOSE_REQ, USR_TX_AFULL,
        input  FIFO_READ, USR_CLOSE_ACK, USR_TX_WE, USR_TX_WD
    );

endinterface

// File: rtl/tcp_tx_framer.sv
// Splits 32-bit words from a FWFT FIFO into a registered byte stream for a TCP
// transmit port, honouring almost-full back-pressure, connection loss and close.
module tcp_tx_framer
    import tcp_tx_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 BUS_CLK,
    input  logic                 RSTn,
    tcp_tx_framer_if.master      bus,
    output logic [CNT_WIDTH-1:0] WORD_CNT,
    output logic [15:0]          DROP_CNT,
    output logic                 BUSY
);

    logic [1:0]           state_q, state_d;
    byte_idx_t            idx_q, idx_d;
    logic [31:0]          word_q, word_d;
    logic                 we_q, we_d;
    logic [7:0]           wd_q, wd_d;
    logic                 ack_q, ack_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic byte_sent;
    logic pop_ok;
    logic fifo_read;

    // The last byte of a word and the next pop share a cycle, which is what
    // sustains one byte per cycle across word boundaries.
    assign byte_sent = (state_q == ST_SEND) && bus.USR_ACTIVE && !bus.USR_TX_AFULL;
    assign pop_ok    = RSTn && bus.USR_ACTIVE && !bus.FIFO_EMPTY && !bus.USR_CLOSE_REQ;
    assign fifo_read = pop_ok &&
                       ((state_q == ST_IDLE) || (byte_sent && (idx_q == LAST_IDX)));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        wd_d       = wd_q;
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ack_d      = (state_q == ST_CLOSE) && bus.USR_CLOSE_REQ;

        case (state_q)
            ST_IDLE: begin
                if (bus.USR_CLOSE_REQ) begin
                    state_d = ST_CLOSE;
                end
            end
            ST_SEND: begin
                if (!bus.USR_ACTIVE) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else if (byte_sent) begin
                    we_d  = 1'b1;
                    wd_d  = select_byte(word_q, idx_q, MSB_FIRST);
                    idx_d = idx_q + byte_idx_t'(1);
                    if (idx_q == LAST_IDX) begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                        state_d    = bus.USR_CLOSE_REQ ? ST_CLOSE : ST_IDLE;
                    end
                end
            end
            ST_CLOSE: begin
                if (!bus.USR_CLOSE_REQ) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (fifo_read) begin
            word_d  = bus.FIFO_DATA;
            idx_d   = '0;
            state_d = ST_SEND;
        end
    end

    always_ff @(posedge BUS_CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            wd_q       <= '0;
            ack_q      <= 1'b0;
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            we_q       <= we_d;
            wd_q       <= wd_d;
            ack_q      <= ack_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.FIFO_READ     = fifo_read;
    assign bus.USR_TX_WE     = we_q;
    assign bus.USR_TX_WD     = wd_q;
    assign bus.USR_CLOSE_ACK = ack_q;
    assign WORD_CNT          = word_cnt_q;
    assign DROP_CNT          = drop_cnt_q;
    assign BUSY              = (state_q != ST_IDLE);

endmodule

// File: doc/tcp_tx_framer.md
TCP_TX_FRAMER -- requirements
Module: tcp_tx_framer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1, meaning byte 0 sent is FIFO_DATA[31:24] (0: FIFO_DATA[7:0] first).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, meaning width of WORD_CNT.
REQ-003 BUS_CLK  in  1  sole clock, all logic rising-edge.
REQ-004 RSTn  in  1  asynchronous, active-low reset.
REQ-005 FIFO_EMPTY  in  1  upstream first-word-fall-through FIFO empty flag.
REQ-006 FIFO_DATA  in  32  upstream word, valid whenever FIFO_EMPTY=0.
REQ-007 FIFO_READ  out  1  one-cycle pop strobe; word is latched in the same cycle.
REQ-008 USR_ACTIVE  in  1  TCP connection established.
REQ-009 USR_CLOSE_REQ  in  1  TCP close request (level).
REQ-010 USR_CLOSE_ACK  out  1  close acknowledge (level).
REQ-011 USR_TX_AFULL  in  1  TCP Tx FIFO almost full.
REQ-012 USR_TX_WE  out  1  TCP Tx byte write enable, registered.
REQ-013 USR_TX_WD  out  8  TCP Tx byte, registered, valid when USR_TX_WE=1.
REQ-014 WORD_CNT  out  CNT_WIDTH  words fully transmitted, wraps at 2^CNT_WIDTH.
REQ-015 DROP_CNT  out  16  words aborted mid-transmission, saturates at 16'hFFFF.
REQ-016 BUSY  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, SEND, CLOSE.
REQ-018 FIFO_READ SHALL be combinational: 1 iff (state=IDLE or (state=SEND and byte index=3 and byte sent this cycle)) and USR_ACTIVE=1 and FIFO_EMPTY=0 and USR_CLOSE_REQ=0.
REQ-019 On FIFO_READ=1 the block SHALL latch FIFO_DATA into a 32-bit word register, set byte index to 0, and enter or stay in SEND.
REQ-020 IDLE: USR_CLOSE_REQ=1 takes priority and SHALL move to CLOSE; otherwise pop per REQ-018.
REQ-021 SEND: in a cycle with USR_TX_AFULL=0 and USR_ACTIVE=1, the block SHALL register USR_TX_WE=1 and USR_TX_WD=byte[index] for the next cycle, then increment the index.
REQ-022 SEND: in a cycle with USR_TX_AFULL=1, the block SHALL register USR_TX_WE=0 and hold the index; at most one byte SHALL be written after AFULL rises.
REQ-023 After byte 3 is sent, WORD_CNT SHALL increment by 1; next state SHALL be SEND if a back-to-back pop occurs (no idle cycle, 1 byte/cycle sustained), else CLOSE if USR_CLOSE_REQ=1, else IDLE.
REQ-024 USR_CLOSE_REQ asserted during SEND SHALL NOT truncate the current word; remaining bytes SHALL be sent first.
REQ-025 USR_ACTIVE=0 during SEND SHALL abort the word: remaining bytes discarded, no WE, DROP_CNT+1 (saturating), next state IDLE.
REQ-026 CLOSE: USR_CLOSE_ACK SHALL be 1 (registered, one cycle after entry) and remain 1 while USR_CLOSE_REQ=1; on USR_CLOSE_REQ=0 it SHALL return to IDLE with USR_CLOSE_ACK=0 on the next cycle.
REQ-027 No FIFO_READ SHALL occur while USR_ACTIVE=0 or in CLOSE; upstream data SHALL remain buffered upstream.
REQ-028 Byte order SHALL follow MSB_FIRST for every word.

Reset
REQ-029 RSTn=0 SHALL asynchronously force state=IDLE, index=0, word register=0, USR_TX_WE=0, USR_TX_WD=0, USR_CLOSE_ACK=0, WORD_CNT=0, DROP_CNT=0, BUSY=0.
REQ-030 FIFO_READ SHALL be 0 while RSTn=0.
REQ-031 Reset mid-word SHALL discard the word without incrementing DROP_CNT.

Structure
REQ-032 State encoding and byte-index width constants SHALL live in a shared package tcp_tx_pkg.
REQ-033 SHALL be a single module; no sub-module needed.

Verification
REQ-034 ACTIVE=1, AFULL=0, FIFO holds 32'hA1B2C3D4 then 32'h11223344 -> WE high 8 consecutive cycles, WD A1,B2,C3,D4,11,22,33,44; FIFO_READ pulses exactly twice; WORD_CNT=2.
REQ-035 AFULL raised after byte B2 of 32'hA1B2C3D4 for 5 cycles -> at most C3 written during AFULL, no other WE; remaining bytes resume after AFULL=0; WORD_CNT=1.
REQ-036 ACTIVE dropped after byte 1 of 32'hDEADBEEF -> only DE,AD written; DROP_CNT=1; WORD_CNT=0; state IDLE; no FIFO_READ until ACTIVE=1.
REQ-037 CLOSE_REQ raised at byte 0 of 32'h01020304 -> all 4 bytes sent, then CLOSE_ACK=1 until CLOSE_REQ=0; FIFO not popped despite FIFO_EMPTY=0.
REQ-038 MSB_FIRST=0, word 32'hA1B2C3D4 -> WD D4,C3,B2,A1.
REQ-039 RSTn pulsed low mid-word -> all outputs at reset values immediately, DROP_CNT=0, next word transmits cleanly from byte 0.
